// File: rtl/scan_pkg.sv
// Shared constants and the width helper for the digit scanner.
package scan_pkg;

  localparam int DEF_N_DIGITS     = 8;
  localparam int DEF_SCAN_DIV     = 4;
  localparam int DEF_DEAD         = 1;
  localparam int DEF_BLINK_FRAMES = 2;

  // Ceiling log2 that never returns less than 1, so a count range of 1 still
  // gets a usable one-bit register.
  function automatic int clog2(input int value);
    int w;
    w = 0;
    while ((1 << w) < value) w++;
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/digit_scanner_if.sv
// Control and display bundle between the scanner and its user.
interface digit_scanner_if
  import scan_pkg::*;
#(
  parameter int N_DIGITS = DEF_N_DIGITS
);

  logic                         enable;
  logic [N_DIGITS-1:0]          blink_mask;
  logic [N_DIGITS-1:0]          blank_mask;
  logic [N_DIGITS-1:0]          an;
  logic [clog2(N_DIGITS)-1:0]   sel;
  logic                         frame_start;
  logic                         blink_phase;

  modport master (
    output enable, blink_mask, blank_mask,
    input  an, sel, frame_start, blink_phase
  );

  modport slave (
    input  enable, blink_mask, blank_mask,
    output an, sel, frame_start, blink_phase
  );

endinterface

// File: rtl/scan_tick_gen.sv
// Dwell counter: counts newclk cycles spent on one digit, flags the end of the
// dwell and whether the upcoming cycle falls in the dark anti-ghosting window.
module scan_tick_gen
  import scan_pkg::*;
#(
  parameter int SCAN_DIV = DEF_SCAN_DIV,
  parameter int DEAD     = DEF_DEAD
) (
  input  logic newclk,
  input  logic rst_n,
  input  logic enable_i,
  output logic tick_o,
  output logic dead_nxt_o
);

  localparam int CNT_W = clog2(SCAN_DIV);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Advance only while enabled; the tick marks the last cycle of a dwell.
  always_comb begin
    tick_o = enable_i && (cnt_q == CNT_W'(SCAN_DIV - 1));
    cnt_d  = cnt_q;
    if (tick_o) begin
      cnt_d = '0;
    end else if (enable_i) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    // Dead flag is for the next cycle so the parent can register its strobes.
    dead_nxt_o = (cnt_d < CNT_W'(DEAD));
  end

  // Dwell counter register.
  always_ff @(posedge newclk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/digit_scanner.sv
// Multiplexed display scanner: digit select, frame/blink timing, tear-free
// mask latching and registered active-low digit strobes.
module digit_scanner
  import scan_pkg::*;
#(
  parameter int N_DIGITS     = DEF_N_DIGITS,
  parameter int SCAN_DIV     = DEF_SCAN_DIV,
  parameter int DEAD         = DEF_DEAD,
  parameter int BLINK_FRAMES = DEF_BLINK_FRAMES
) (
  input  logic           newclk,
  input  logic           rst_n,
  digit_scanner_if.slave bus
);

  localparam int SEL_W = clog2(N_DIGITS);
  localparam int FRM_W = clog2(BLINK_FRAMES);

  logic                tick;
  logic                dead_nxt;
  logic                wrap;
  logic [SEL_W-1:0]    sel_q, sel_d;
  logic [FRM_W-1:0]    frm_q, frm_d;
  logic                blink_phase_q, blink_phase_d;
  logic                frame_start_q, frame_start_d;
  logic [N_DIGITS-1:0] blink_lat_q, blink_lat_d;
  logic [N_DIGITS-1:0] blank_lat_q, blank_lat_d;
  logic [N_DIGITS-1:0] an_q, an_d;
  logic [N_DIGITS-1:0] strobe;

  scan_tick_gen #(
    .SCAN_DIV (SCAN_DIV),
    .DEAD     (DEAD)
  ) u_tick (
    .newclk     (newclk),
    .rst_n      (rst_n),
    .enable_i   (bus.enable),
    .tick_o     (tick),
    .dead_nxt_o (dead_nxt)
  );

  // Next state for digit select, frame/blink counters, mask latches and the
  // strobe pattern of the upcoming cycle (so an is driven from a register).
  always_comb begin
    wrap          = tick && (sel_q == SEL_W'(N_DIGITS - 1));
    sel_d         = sel_q;
    frm_d         = frm_q;
    blink_phase_d = blink_phase_q;
    blink_lat_d   = blink_lat_q;
    blank_lat_d   = blank_lat_q;
    frame_start_d = wrap;

    if (tick) begin
      sel_d = wrap ? '0 : sel_q + SEL_W'(1);
    end

    // Masks and blink timing change only at a frame boundary.
    if (wrap) begin
      blink_lat_d = bus.blink_mask;
      blank_lat_d = bus.blank_mask;
      if (frm_q == FRM_W'(BLINK_FRAMES - 1)) begin
        frm_d         = '0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        frm_d = frm_q + FRM_W'(1);
      end
    end

    // Digit 0 drives the MSB strobe.
    strobe = {1'b1, {(N_DIGITS-1){1'b0}}} >> sel_d;
    an_d   = ~strobe;
    if (dead_nxt || (|(blank_lat_d & strobe)) ||
        (blink_phase_d && (|(blink_lat_d & strobe)))) begin
      an_d = '1;
    end
  end

  // Scanner state registers; reset forces all strobes off immediately.
  always_ff @(posedge newclk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q         <= '0;
      frm_q         <= '0;
      blink_phase_q <= 1'b0;
      frame_start_q <= 1'b0;
      blink_lat_q   <= '0;
      blank_lat_q   <= '0;
      an_q          <= '1;
    end else begin
      sel_q         <= sel_d;
      frm_q         <= frm_d;
      blink_phase_q <= blink_phase_d;
      frame_start_q <= frame_start_d;
      blink_lat_q   <= blink_lat_d;
      blank_lat_q   <= blank_lat_d;
      an_q          <= an_d;
    end
  end

  // Enable gating is the only direct input-to-output path.
  assign bus.an          = bus.enable ? an_q : '1;
  assign bus.sel         = sel_q;
  assign bus.frame_start = frame_start_q;
  assign bus.blink_phase = blink_phase_q;

endmodule

// File: doc/digit_scanner.md
DIGIT_SCANNER -- requirements
Module: digit_scanner

Interface
REQ-001 Parameter N_DIGITS, default 8: number of multiplexed display digits, legal range 2..16.
REQ-002 Parameter SCAN_DIV, default 4: newclk cycles each digit is dwelled on, legal range 2..65535.
REQ-003 Parameter DEAD, default 1: anti-ghosting cycles at the start of each dwell with all digits off; requires 0 <= DEAD < SCAN_DIV.
REQ-004 Parameter BLINK_FRAMES, default 2: full scan frames per blink half-period, legal range >= 1.
REQ-005 newclk  in  1  sole clock; all state updates on its rising edge.
REQ-006 rst_n  in  1  asynchronous, active-low reset.
REQ-007 enable  in  1  1 = scan runs; 0 = freeze the counters and blank the display.
REQ-008 blink_mask  in  N_DIGITS  bit k = 1 makes the digit driven on an[k] blink.
REQ-009 blank_mask  in  N_DIGITS  bit k = 1 keeps an[k] permanently off.
REQ-010 an  out  N_DIGITS  digit strobes, active-low, at most one bit low at a time.
REQ-011 sel  out  clog2(N_DIGITS)  index of the current digit, for the external segment mux.
REQ-012 frame_start  out  1  one-cycle pulse when sel wraps to 0.
REQ-013 blink_phase  out  1  0 = blinking digits visible; 1 = blinking digits dark.

Function
REQ-014 The dwell counter cnt SHALL count 0..SCAN_DIV-1 while enable=1 and SHALL wrap to 0.
REQ-015 sel SHALL increment when cnt=SCAN_DIV-1 and SHALL wrap from N_DIGITS-1 to 0.
REQ-016 Digit index i SHALL drive an bit N_DIGITS-1-i low, so digit 0 maps to the MSB.
REQ-017 an SHALL be all ones when cnt<DEAD, enable=0, the latched blank bit is set, or (blink_phase=1 and the latched blink bit is set).
REQ-018 In all other cases an SHALL have exactly the selected digit's bit low.
REQ-019 frame_start SHALL be 1 for exactly the single cycle in which sel=0 and cnt=0 after a wrap.
REQ-020 frame_start SHALL NOT pulse in the first cycle after reset release.
REQ-021 blink_mask and blank_mask SHALL be latched only on the cycle frame_start is asserted, so a mask change never tears mid-frame.
REQ-022 The frame counter SHALL count frames 0..BLINK_FRAMES-1.
REQ-023 blink_phase SHALL toggle on the frame_start cycle that wraps the frame counter.
REQ-024 Full blink period SHALL be 2*BLINK_FRAMES*N_DIGITS*SCAN_DIV cycles.
REQ-025 With enable=0, cnt, sel, the frame counter, blink_phase and the latched masks SHALL hold their values.
REQ-026 When enable returns to 1, the scan SHALL resume from the held state with no skipped or repeated dwell cycle.
REQ-027 an, sel, frame_start and blink_phase SHALL be functions of registered state only, with no combinational path from any input.
REQ-028 Exception to REQ-027: the enable blanking in REQ-017 is the only combinational input-to-output path permitted.

Reset
REQ-029 While rst_n=0: cnt=0, sel=0, frame counter=0, blink_phase=0, latched masks=0, frame_start=0, an=all ones.
REQ-030 Reset asserted mid-dwell or mid-frame SHALL take effect immediately, without waiting for a clock edge.
REQ-031 After reset release, the first dwell SHALL be digit 0, beginning with DEAD dark cycles.

Structure
REQ-032 A shared package scan_pkg SHALL hold the width function (clog2) and the default parameter constants.
REQ-033 Sub-module scan_tick_gen SHALL implement cnt and emit a dwell-end tick and a dead-window flag.
REQ-034 The parent module SHALL hold sel, the frame/blink logic and the mask latches.

Verification (N_DIGITS=8, SCAN_DIV=4, DEAD=1, BLINK_FRAMES=2)
REQ-035 Release reset, enable=1, masks=0 -> an = FF,7F,7F,7F, FF,BF,BF,BF, ... through FE.
REQ-036 Continuing REQ-035 -> 32-cycle frame; frame_start pulses every 32 cycles, beginning at the first wrap.
REQ-037 blink_mask=03 applied before a frame_start -> an bits 1:0 strobe in 2 frames, stay dark for 2 frames; period 128 cycles; blink_phase toggles every 64 cycles.
REQ-038 blank_mask changed from 00 to 80 mid-frame -> 7F still appears until the next frame_start, then an[7] never goes low; sel keeps scanning.
REQ-039 enable=0 for 10 cycles at sel=3, cnt=2 -> an=FF and sel=3 are held; on resume, cnt continues 2,3 and the digit-3 dwell completes.
REQ-040 rst_n pulsed low between clock edges at sel=5 -> an=FF and sel=0 immediately; the scan restarts at digit 0.
